// File: rtl/ph_cache_sched.sv
// ph_cache_sched: ping-pong frame bank control plus a round-robin
// read scheduler for a two-bank cache shared by CPU and baseline engine.
module ph_cache_sched #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_done,
  output logic              wr_bank,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              bl_req,
  input  logic [ADDR_W-1:0] bl_addr,
  output logic              bl_gnt,
  output logic              bl_rvalid,
  output logic              bl_frame_ready,
  input  logic              bl_frame_ack,
  output logic              mem_en,
  output logic              mem_bank,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic [15:0]       overrun_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state;
  logic              wr_bank_n;
  logic              cpu_elig;
  logic              bl_elig;
  logic              take_cpu;
  logic              take_bl;
  logic              rr_bl;
  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_bl;

  assign bl_frame_ready = (state == READY);

  // Writer bank for the coming cycle; an issue targets its complement
  always_comb begin
    wr_bank_n = wr_bank;
    if (wr_done && (state == EMPTY || bl_frame_ack))
      wr_bank_n = ~wr_bank;
  end

  // Bank FSM: frame handoff, consumption and overrun counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      wr_bank     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (wr_done)
            state <= READY;
        end
        READY: begin
          if (wr_done && !bl_frame_ack) begin
            if (overrun_cnt != 16'hFFFF)
              overrun_cnt <= overrun_cnt + 16'd1;
          end else if (!wr_done && bl_frame_ack) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
      wr_bank <= wr_bank_n;
    end
  end

  // Eligibility masks the request already granted this cycle
  always_comb begin
    cpu_elig = cpu_req && !cpu_gnt;
    bl_elig  = bl_req && !bl_gnt && (state == READY);
    take_bl  = bl_elig && (!cpu_elig || rr_bl);
    take_cpu = cpu_elig && !take_bl;
  end

  // Issue stage: one registered read per cycle, address/bank held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_gnt  <= 1'b0;
      bl_gnt   <= 1'b0;
      mem_en   <= 1'b0;
      mem_bank <= 1'b1;
      mem_addr <= '0;
      rr_bl    <= 1'b0;
    end else begin
      cpu_gnt <= take_cpu;
      bl_gnt  <= take_bl;
      mem_en  <= take_cpu | take_bl;
      if (take_cpu) begin
        mem_addr <= cpu_addr;
        mem_bank <= ~wr_bank_n;
        rr_bl    <= 1'b1;
      end else if (take_bl) begin
        mem_addr <= bl_addr;
        mem_bank <= ~wr_bank_n;
        rr_bl    <= 1'b0;
      end
    end
  end

  // Owner-tag pipeline steers returning data to the issuing requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v     <= '0;
      pipe_bl    <= '0;
      cpu_rvalid <= 1'b0;
      bl_rvalid  <= 1'b0;
      rdata      <= '0;
    end else begin
      pipe_v[0]  <= mem_en;
      pipe_bl[0] <= bl_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_bl[i] <= pipe_bl[i-1];
      end
      cpu_rvalid <= pipe_v[RD_LAT-1] & ~pipe_bl[RD_LAT-1];
      bl_rvalid  <= pipe_v[RD_LAT-1] & pipe_bl[RD_LAT-1];
      if (pipe_v[RD_LAT-1])
        rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_ph_cache_sched.sv
// tb_ph_cache_sched: directed stimulus, behavioural reference model
// and per-cycle output comparison for ph_cache_sched.
module tb_ph_cache_sched;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_done = 1'b0;
  logic          wr_bank;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic          bl_req = 1'b0;
  logic [AW-1:0] bl_addr = '0;
  logic          bl_gnt;
  logic          bl_rvalid;
  logic          bl_frame_ready;
  logic          bl_frame_ack = 1'b0;
  logic          mem_en;
  logic          mem_bank;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] rdata;
  logic [15:0]   overrun_cnt;

  ph_cache_sched #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .wr_done(wr_done), .wr_bank(wr_bank),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .bl_req(bl_req), .bl_addr(bl_addr),
    .bl_gnt(bl_gnt), .bl_rvalid(bl_rvalid),
    .bl_frame_ready(bl_frame_ready), .bl_frame_ack(bl_frame_ack),
    .mem_en(mem_en), .mem_bank(mem_bank), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .rdata(rdata), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int nprint = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (nprint < 40) begin
        nprint++;
        $display("FAIL %s actual=%0h required=%0h t=%0t",
                 nm, act, exp, $time);
      end
    end
  endtask

  // cache contents: every word encodes its own bank and address
  function automatic logic [15:0] word(input bit b, input logic [7:0] a);
    return {7'h58, b, a};
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    bit         bl;
    bit         bank;
    logic [7:0] addr;
  } rd_t;

  rd_t         pend[$];
  int          n = 0;
  bit          m_ready, m_wrb, m_cg, m_bg, m_en, m_bank;
  bit          m_crv, m_brv, m_last_cpu;
  logic [15:0] m_ovr, m_rdata;
  logic [7:0]  m_addr;

  task automatic model_reset();
    pend.delete();
    m_ready = 0; m_wrb = 0; m_cg = 0; m_bg = 0; m_en = 0;
    m_bank = 1; m_crv = 0; m_brv = 0; m_last_cpu = 0;
    m_ovr = 0; m_rdata = 0; m_addr = 0;
  endtask

  task automatic model_step();
    bit  ce, be, gc, gb;
    rd_t r;
    n++;
    ce = cpu_req && !m_cg;
    be = bl_req && !m_bg && m_ready;
    if (wr_done && (!m_ready || bl_frame_ack)) begin
      m_wrb = !m_wrb;
      m_ready = 1;
    end else if (wr_done) begin
      if (m_ovr != 16'hFFFF) m_ovr++;
    end else if (bl_frame_ack) begin
      m_ready = 0;
    end
    m_crv = 0;
    m_brv = 0;
    if (pend.size() > 0 && pend[0].due == n) begin
      r = pend.pop_front();
      if (r.bl) m_brv = 1; else m_crv = 1;
      m_rdata = word(r.bank, r.addr);
    end
    gc = ce && (!be || !m_last_cpu);
    gb = be && !gc;
    m_cg = gc;
    m_bg = gb;
    m_en = gc | gb;
    if (m_en) begin
      m_addr = gc ? cpu_addr : bl_addr;
      m_bank = !m_wrb;
      r.due = n + RL + 1;
      r.bl = gb;
      r.bank = m_bank;
      r.addr = m_addr;
      pend.push_back(r);
      m_last_cpu = gc;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // compare every output against the model each cycle
  initial begin
    forever begin
      @(negedge clk);
      chk("wr_bank", wr_bank, m_wrb);
      chk("bl_frame_ready", bl_frame_ready, m_ready);
      chk("overrun_cnt", overrun_cnt, m_ovr);
      chk("cpu_gnt", cpu_gnt, m_cg);
      chk("bl_gnt", bl_gnt, m_bg);
      chk("mem_en", mem_en, m_en);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_bank", mem_bank, m_bank);
      chk("cpu_rvalid", cpu_rvalid, m_crv);
      chk("bl_rvalid", bl_rvalid, m_brv);
      chk("rdata", rdata, m_rdata);
    end
  end

  // cache read port: data appears RL cycles after the issue cycle
  logic [8:0] h [4];
  initial begin
    for (int i = 0; i < 4; i++) h[i] = '0;
    forever begin
      @(negedge clk);
      for (int i = 3; i > 0; i--) h[i] = h[i-1];
      h[0] = {mem_bank, mem_addr};
      @(posedge clk);
      #1;
      mem_rdata = word(h[RL-1][8], h[RL-1][7:0]);
    end
  end

  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wr_bank"}, wr_bank, 0);
    chk({tag, "_ready"}, bl_frame_ready, 0);
    chk({tag, "_ovr"}, overrun_cnt, 0);
    chk({tag, "_cpu_gnt"}, cpu_gnt, 0);
    chk({tag, "_bl_gnt"}, bl_gnt, 0);
    chk({tag, "_cpu_rv"}, cpu_rvalid, 0);
    chk({tag, "_bl_rv"}, bl_rvalid, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_bank"}, mem_bank, 1);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  logic [3:0] tbl [12] = '{
    4'b1100, 4'b1100, 4'b1110, 4'b1100,
    4'b1101, 4'b1100, 4'b0010, 4'b1100,
    4'b1111, 4'b0100, 4'b1010, 4'b1001
  };

  initial begin
    #1 rst = 1'b1;
    tick(3);
    chk_reset("reset");
    rst = 1'b0;
    tick(2);

    // first frame handoff
    wr_done = 1; tick(); wr_done = 0;
    chk("hand_wr_bank", wr_bank, 1);
    chk("hand_ready", bl_frame_ready, 1);
    chk("hand_ovr", overrun_cnt, 0);

    // both requesting: grants alternate
    cpu_req = 1; bl_req = 1;
    cpu_addr = 8'h10; bl_addr = 8'h20;
    tick();
    chk("alt1_cpu", cpu_gnt, 1);
    chk("alt1_bl", bl_gnt, 0);
    chk("alt1_addr", mem_addr, 8'h10);
    chk("alt1_bank", mem_bank, 0);
    tick();
    chk("alt2_bl", bl_gnt, 1);
    chk("alt2_cpu", cpu_gnt, 0);
    chk("alt2_addr", mem_addr, 8'h20);
    tick();
    chk("alt3_cpu", cpu_gnt, 1);
    chk("alt3_addr", mem_addr, 8'h10);
    tick();
    chk("alt4_bl", bl_gnt, 1);
    chk("alt4_addr", mem_addr, 8'h20);
    chk("alt_rv1_cpu", cpu_rvalid, 1);
    chk("alt_rv1_data", rdata, 16'hB010);
    cpu_req = 0; bl_req = 0;
    tick();
    chk("alt_rv2_bl", bl_rvalid, 1);
    chk("alt_rv2_data", rdata, 16'hB020);
    chk("alt_idle_en", mem_en, 0);
    tick();
    chk("alt_rv3_cpu", cpu_rvalid, 1);
    tick();
    chk("alt_rv4_bl", bl_rvalid, 1);
    tick(2);

    // EMPTY: baseline locked out, CPU still served
    bl_frame_ack = 1; tick(); bl_frame_ack = 0;
    chk("ack_ready", bl_frame_ready, 0);
    bl_req = 1; bl_addr = 8'h21;
    repeat (3) begin
      tick();
      chk("empty_no_bl_gnt", bl_gnt, 0);
    end
    cpu_req = 1; cpu_addr = 8'h33;
    tick();
    chk("empty_cpu_gnt", cpu_gnt, 1);
    chk("empty_cpu_addr", mem_addr, 8'h33);
    cpu_req = 0; bl_req = 0;
    tick(4);
    bl_frame_ack = 1; tick(); bl_frame_ack = 0;
    chk("ack_in_empty", bl_frame_ready, 0);

    // overruns
    wr_done = 1; tick(); wr_done = 0;
    chk("refill_wr_bank", wr_bank, 0);
    chk("refill_ready", bl_frame_ready, 1);
    repeat (3) begin
      wr_done = 1; tick(); wr_done = 0; tick();
    end
    chk("ovr3_cnt", overrun_cnt, 3);
    chk("ovr3_wr_bank", wr_bank, 0);
    chk("ovr3_ready", bl_frame_ready, 1);

    // simultaneous done and ack
    wr_done = 1; bl_frame_ack = 1; tick();
    wr_done = 0; bl_frame_ack = 0;
    chk("both_wr_bank", wr_bank, 1);
    chk("both_ready", bl_frame_ready, 1);
    chk("both_ovr", overrun_cnt, 3);

    // mixed traffic across bank changes
    for (int i = 0; i < 12; i++) begin
      {cpu_req, bl_req, wr_done, bl_frame_ack} = tbl[i];
      cpu_addr = 8'(8'h40 + i);
      bl_addr = 8'(8'h80 + i);
      tick();
    end
    {cpu_req, bl_req, wr_done, bl_frame_ack} = 4'b0000;
    tick(6);

    // reset one cycle after a grant discards the read
    cpu_req = 1; cpu_addr = 8'h44;
    tick();
    chk("rstmid_gnt", cpu_gnt, 1);
    cpu_req = 0;
    tick();
    rst = 1;
    #1;
    chk_reset("rstmid_a");
    tick(2);
    chk_reset("rstmid_b");
    rst = 0;
    repeat (6) begin
      tick();
      chk("rstmid_cpu_rv", cpu_rvalid, 0);
      chk("rstmid_bl_rv", bl_rvalid, 0);
    end

    // overrun counter saturation
    wr_done = 1;
    tick();
    chk("sat_ready", bl_frame_ready, 1);
    chk("sat_wr_bank", wr_bank, 1);
    tick(65534);
    chk("sat_fffe", overrun_cnt, 16'hFFFE);
    tick();
    chk("sat_ffff", overrun_cnt, 16'hFFFF);
    tick(5);
    chk("sat_hold", overrun_cnt, 16'hFFFF);
    wr_done = 0;
    tick(2);
    chk("sat_final", overrun_cnt, 16'hFFFF);
    chk("sat_final_bank", wr_bank, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
